// File: rtl/mc_control_fsm_if.sv
// Control/handshake bundle between the instruction register, memory and the
// multi-cycle control FSM.
interface mc_control_fsm_if #(
  parameter int unsigned OP_W  = 6,
  parameter int unsigned CNT_W = 32
);
  logic [OP_W-1:0]  opcode;
  logic             mem_ready;
  logic             resume;
  logic [3:0]       state;
  logic [3:0]       next_state;
  logic             mem_req;
  logic             instr_done;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] instr_count;

  // Environment side: supplies opcode and handshakes, observes control state.
  modport master (
    output opcode, mem_ready, resume,
    input  state, next_state, mem_req, instr_done, halted, fault, instr_count
  );

  // FSM side.
  modport slave (
    input  opcode, mem_ready, resume,
    output state, next_state, mem_req, instr_done, halted, fault, instr_count
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Registered multi-cycle control FSM for the MIPS core: opcode-directed
// EXE/MEM/WB sequencing, memory wait-states with timeout, HALT/resume and a
// retired-instruction counter.
module mc_control_fsm #(
  parameter int unsigned OP_W     = 6,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input logic           CLK,
  input logic           Reset,
  mc_control_fsm_if.slave bus
);

  localparam int unsigned WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [3:0] {
    StIf   = 4'b0000,
    StId   = 4'b0001,
    StCExe = 4'b0010,
    StMem  = 4'b0011,
    StCWb  = 4'b0100,
    StBExe = 4'b0101,
    StAExe = 4'b0110,
    StAWb  = 4'b0111,
    StHalt = 4'b1000
  } state_e;

  state_e            state_q, state_d;
  logic              instr_done_q;
  logic              fault_q;
  logic [CNT_W-1:0]  instr_count_q;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              retire;
  logic              timeout;
  logic              wait_hit;
  logic [5:0]        op;

  // Only the top six opcode bits take part in decode.
  assign op       = bus.opcode[OP_W-1 -: 6];
  assign wait_hit = (WAIT_MAX != 0) && (wait_q == WAIT_W'(WAIT_MAX));

  // State, wait counter, retire pulse/counter and sticky fault registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q       <= StIf;
      wait_q        <= '0;
      instr_done_q  <= 1'b0;
      fault_q       <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      instr_done_q <= retire;
      fault_q      <= fault_q | timeout;
      if (retire) begin
        instr_count_q <= instr_count_q + CNT_W'(1);
      end
    end
  end

  // Next-state decode, retire and timeout detection.
  always_comb begin
    state_d = StIf;
    retire  = 1'b0;
    timeout = 1'b0;
    case (state_q)
      StIf: begin
        // A ready arriving on the timeout cycle still completes normally.
        if (bus.mem_ready) begin
          state_d = StId;
        end else if (wait_hit) begin
          state_d = StHalt;
          timeout = 1'b1;
        end else begin
          state_d = StIf;
        end
      end
      StId: begin
        case (op[5:3])
          3'b110: state_d = (op == 6'b110100 || op == 6'b110101) ? StBExe : StCExe;
          3'b111: begin
            state_d = (op == 6'b111111) ? StHalt : StIf;
            retire  = 1'b1;
          end
          default: state_d = StAExe;
        endcase
      end
      StCExe: state_d = StMem;
      StMem: begin
        if (bus.mem_ready) begin
          if (op == 6'b110001) begin
            state_d = StCWb;
          end else begin
            state_d = StIf;
            retire  = 1'b1;
          end
        end else if (wait_hit) begin
          state_d = StHalt;
          timeout = 1'b1;
        end else begin
          state_d = StMem;
        end
      end
      StCWb: begin
        state_d = StIf;
        retire  = 1'b1;
      end
      StBExe: begin
        state_d = StIf;
        retire  = 1'b1;
      end
      StAExe: state_d = StAWb;
      StAWb: begin
        state_d = StIf;
        retire  = 1'b1;
      end
      StHalt:  state_d = bus.resume ? StIf : StHalt;
      default: state_d = StIf;
    endcase
  end

  // Wait counter: cleared on any state change, counts unanswered requests.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == StIf || state_q == StMem) && !bus.mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Output drive.
  always_comb begin
    bus.state       = state_q;
    bus.next_state  = state_d;
    bus.mem_req     = (state_q == StIf) || (state_q == StMem);
    bus.instr_done  = instr_done_q;
    bus.halted      = (state_q == StHalt);
    bus.fault       = fault_q;
    bus.instr_count = instr_count_q;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm; a monitor checks every instr_done pulse
// against a queue of expected retire results.
module tb_mc_control_fsm;

  localparam logic [3:0] S_IF   = 4'h0;
  localparam logic [3:0] S_ID   = 4'h1;
  localparam logic [3:0] S_CEXE = 4'h2;
  localparam logic [3:0] S_MEM  = 4'h3;
  localparam logic [3:0] S_CWB  = 4'h4;
  localparam logic [3:0] S_HALT = 4'h8;

  typedef struct packed {
    logic [31:0] cnt;
    logic [3:0]  st;
    logic        flt;
  } exp_t;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] opcode_v;
  logic       mem_ready_v;
  logic       resume_v;

  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  mc_control_fsm_if #(.OP_W(6), .CNT_W(32)) bus ();
  mc_control_fsm_if #(.OP_W(6), .CNT_W(4))  bus_w ();

  assign bus.opcode      = opcode_v;
  assign bus.mem_ready   = mem_ready_v;
  assign bus.resume      = resume_v;
  assign bus_w.opcode    = opcode_v;
  assign bus_w.mem_ready = mem_ready_v;
  assign bus_w.resume    = resume_v;

  mc_control_fsm #(.OP_W(6), .WAIT_MAX(15), .CNT_W(32)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  mc_control_fsm #(.OP_W(6), .WAIT_MAX(15), .CNT_W(4)) dut_w (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_retire(input logic [3:0] st, input logic flt);
    exp_t e;
    exp_cnt++;
    e.cnt = exp_cnt;
    e.st  = st;
    e.flt = flt;
    sb.push_back(e);
  endtask

  // seq holds n state nibbles, first state in the most significant used nibble.
  task automatic run_seq(input string name, input logic [31:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      check({name, "_state"}, bus.state, seq[4*(n-1-i) +: 4]);
      if (i < n - 1) begin
        check({name, "_next"}, bus.next_state, seq[4*(n-2-i) +: 4]);
        tick();
      end
    end
  endtask

  // Retire monitor.
  always @(negedge CLK) begin
    if (bus.instr_done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got instr_done=1 count=%0d, want no retire",
                 bus.instr_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("retire_count", bus.instr_count, e.cnt);
        check("retire_state", bus.state, e.st);
        check("retire_fault", bus.fault, e.flt);
      end
    end
  end

  initial begin
    Reset       = 1'b1;
    opcode_v    = 6'b000000;
    mem_ready_v = 1'b0;
    resume_v    = 1'b0;
    repeat (2) tick();
    check("rst_state", bus.state, S_IF);
    check("rst_mem_req", bus.mem_req, 1);
    check("rst_done", bus.instr_done, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_count", bus.instr_count, 0);
    check("rst_halted", bus.halted, 0);
    Reset       = 1'b0;
    mem_ready_v = 1'b1;

    // R-type
    push_retire(S_IF, 1'b0);
    run_seq("rtype", 32'h01670, 5);

    // lw with three unanswered cycles in MEM
    opcode_v = 6'b110001;
    push_retire(S_IF, 1'b0);
    run_seq("lw_head", 32'h0123, 4);
    check("lw_mem_req", bus.mem_req, 1);
    mem_ready_v = 1'b0;
    #1;
    check("lw_mem_hold_next", bus.next_state, S_MEM);
    repeat (3) begin
      tick();
      check("lw_mem_hold", bus.state, S_MEM);
    end
    mem_ready_v = 1'b1;
    run_seq("lw_tail", 32'h340, 3);
    check("lw_fault", bus.fault, 0);

    // sw, beq, bne, j, I-type ALU
    opcode_v = 6'b110000;
    push_retire(S_IF, 1'b0);
    run_seq("sw", 32'h01230, 5);
    opcode_v = 6'b110100;
    push_retire(S_IF, 1'b0);
    run_seq("beq", 32'h0150, 4);
    opcode_v = 6'b110101;
    push_retire(S_IF, 1'b0);
    run_seq("bne", 32'h0150, 4);
    opcode_v = 6'b111000;
    push_retire(S_IF, 1'b0);
    run_seq("j", 32'h010, 3);
    check("count_after_branches", bus.instr_count, 6);
    opcode_v = 6'b101011;
    push_retire(S_IF, 1'b0);
    run_seq("itype", 32'h01670, 5);

    // IF wait; ready arrives exactly on the timeout cycle
    opcode_v    = 6'b000000;
    mem_ready_v = 1'b0;
    repeat (14) tick();
    check("bnd_pre_next", bus.next_state, S_IF);
    tick();
    check("bnd_hit_next", bus.next_state, S_HALT);
    mem_ready_v = 1'b1;
    push_retire(S_IF, 1'b0);
    #1;
    check("bnd_ready_next", bus.next_state, S_ID);
    tick();
    check("bnd_fault", bus.fault, 0);
    run_seq("bnd", 32'h1670, 4);

    // IF timeout into HALT
    mem_ready_v = 1'b0;
    repeat (15) tick();
    check("to_next", bus.next_state, S_HALT);
    tick();
    check("to_state", bus.state, S_HALT);
    check("to_halted", bus.halted, 1);
    check("to_fault", bus.fault, 1);
    check("to_count", bus.instr_count, exp_cnt);
    check("to_mem_req", bus.mem_req, 0);
    tick();
    check("to_stay", bus.state, S_HALT);
    resume_v = 1'b1;
    tick();
    resume_v = 1'b0;
    check("resume_state", bus.state, S_IF);
    check("resume_fault", bus.fault, 1);
    check("resume_halted", bus.halted, 0);

    // halt instruction retires on entering HALT
    mem_ready_v = 1'b1;
    opcode_v    = 6'b111111;
    push_retire(S_HALT, 1'b1);
    run_seq("halt", 32'h018, 3);
    check("halt_halted", bus.halted, 1);
    resume_v = 1'b1;
    tick();
    resume_v = 1'b0;
    check("halt_resume", bus.state, S_IF);

    // MEM timeout
    opcode_v = 6'b110000;
    run_seq("memto_head", 32'h0123, 4);
    mem_ready_v = 1'b0;
    repeat (15) tick();
    check("memto_next", bus.next_state, S_HALT);
    tick();
    check("memto_state", bus.state, S_HALT);
    check("memto_count", bus.instr_count, exp_cnt);
    mem_ready_v = 1'b1;
    resume_v    = 1'b1;
    tick();
    resume_v = 1'b0;

    // asynchronous reset mid-cEXE
    opcode_v = 6'b110001;
    run_seq("rst_mid", 32'h012, 3);
    Reset = 1'b1;
    #1;
    check("arst_state", bus.state, S_IF);
    check("arst_count", bus.instr_count, 0);
    check("arst_fault", bus.fault, 0);
    check("arst_done", bus.instr_done, 0);
    check("arst_mem_req", bus.mem_req, 1);
    tick();
    Reset   = 1'b0;
    exp_cnt = 0;

    // 16 R-types: 4-bit counter wraps
    opcode_v = 6'b000000;
    for (int k = 0; k < 16; k++) begin
      push_retire(S_IF, 1'b0);
      run_seq("wrap", 32'h01670, 5);
      if (k == 14) check("wrap_15", bus_w.instr_count, 15);
    end
    check("wrap_0", bus_w.instr_count, 0);
    check("wide_16", bus.instr_count, 16);

    repeat (2) tick();
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
